// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch, decode and per-class
// execute steps, with memReady stretching the FETCH, MEMRD and MEMWR states.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
  } stateE;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  stateE stateQ;
  stateE stateNext;
  stateE decState;
  logic  fetchStrobe;

  always_comb begin
    stateNext = StFetch;
    case (stateQ)
      StFetch:  stateNext = memReady ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OpRType:     stateNext = StExec;
          OpLw, OpSw:  stateNext = StMemAdr;
          OpBeq:       stateNext = StBranch;
          OpJ:         stateNext = StJump;
          OpAddi:      stateNext = StAddiEx;
          default:     stateNext = StFetch;
        endcase
      end
      StMemAdr: stateNext = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  stateNext = memReady ? StMemWb : StMemRd;
      StMemWb:  stateNext = StFetch;
      StMemWr:  stateNext = memReady ? StFetch : StMemWr;
      StExec:   stateNext = StRwb;
      StRwb:    stateNext = StFetch;
      StBranch: stateNext = StFetch;
      StJump:   stateNext = StFetch;
      StAddiEx: stateNext = StAddiWb;
      StAddiWb: stateNext = StFetch;
      default:  stateNext = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ <= StFetch;
    end else begin
      stateQ <= stateNext;
    end
  end

  // While reset is held, decode as FETCH right away so no strobe from an interrupted
  // state (e.g. a MEMWR wait) leaks through before the register is cleared.
  assign decState    = rst_n ? stateQ : StFetch;
  assign fetchStrobe = memReady & rst_n;

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcSource    = 2'b00;
    case (decState)
      StFetch: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = fetchStrobe;
        pcWrite = fetchStrobe;
      end
      StDecode: aluSrcB = 2'b11;
      StMemAdr: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      StMemRd: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      StMemWb: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      StMemWr: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      StExec: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
      end
      StRwb: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
      end
      StBranch: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
      end
      StJump: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
      end
      StAddiEx: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      StAddiWb: regWrite = 1'b1;
      default: ;
    endcase
  end

  assign state = stateQ;

  assert property (@(posedge clk) !(memWrite && regWrite));

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table for the documented sequences and
// reset corners, then random instruction streams against a path-based reference model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       memReady;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regDst, regWrite, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .memReady   (memReady),
    .pcWrite    (pcWrite),
    .pcWriteCond(pcWriteCond),
    .iorD       (iorD),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .irWrite    (irWrite),
    .memToReg   (memToReg),
    .regDst     (regDst),
    .regWrite   (regWrite),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .aluOp      (aluOp),
    .pcSource   (pcSource),
    .state      (state)
  );

  // Output word: {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
  //               regDst, regWrite, aluSrcA, aluSrcB[1:0], aluOp[1:0], pcSource[1:0]}
  logic [15:0] outs;
  assign outs = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                 regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource};

  localparam logic [15:0] OFetch  = 16'h1010;  // memRead, aluSrcB=01
  localparam logic [15:0] RdyBits = 16'h8400;  // pcWrite, irWrite
  localparam logic [15:0] OFetchR = OFetch | RdyBits;
  localparam logic [15:0] ODecode = 16'h0030;
  localparam logic [15:0] OMemAdr = 16'h0060;
  localparam logic [15:0] OMemRd  = 16'h3000;
  localparam logic [15:0] OMemWb  = 16'h0280;
  localparam logic [15:0] OMemWr  = 16'h2800;
  localparam logic [15:0] OExec   = 16'h0048;
  localparam logic [15:0] ORwb    = 16'h0180;
  localparam logic [15:0] OBranch = 16'h4045;
  localparam logic [15:0] OJump   = 16'h8002;
  localparam logic [15:0] OAddiEx = 16'h0060;
  localparam logic [15:0] OAddiWb = 16'h0080;

  localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100, OpJ = 6'b000010, OpAddi = 6'b001000;
  localparam logic [5:0] OpBad = 6'b111111;

  typedef struct {
    logic        rstN;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] out;
  } vecT;

  vecT         vecs[$];
  logic [15:0] outTab[12];
  int          path[$];
  int          nChecks = 0;
  int          nFail = 0;
  int          pcWrites;
  logic [5:0]  legal[6];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] op, input logic mr,
                      input logic [3:0] es, input logic [15:0] eo, input string nm);
    @(negedge clk);
    rst_n    = r;
    opcode   = op;
    memReady = mr;
    #1;
    check({nm, " state"}, {12'h0, state}, {12'h0, es});
    check({nm, " outputs"}, outs, eo);
    check({nm, " memWrite&regWrite"}, {15'h0, memWrite & regWrite}, 16'h0);
    if (es != 4'd9 && pcWrite) pcWrites++;
  endtask

  function automatic bit isLegal(input logic [5:0] op);
    foreach (legal[i]) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Expected state walk of one instruction with memory always ready.
  function automatic void buildPath(input logic [5:0] op);
    path = {0, 1};
    case (op)
      OpR:     path = {path, 6, 7};
      OpLw:    path = {path, 2, 3, 4};
      OpSw:    path = {path, 2, 5};
      OpBeq:   path = {path, 8};
      OpJ:     path = {path, 9};
      OpAddi:  path = {path, 10, 11};
      default: ;
    endcase
  endfunction

  function automatic void addVec(input logic r, input logic [5:0] op, input logic mr,
                                 input logic [3:0] st, input logic [15:0] out);
    vecT v;
    v.rstN = r; v.op = op; v.mr = mr; v.st = st; v.out = out;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [5:0] op;
    int         st;
    int         waits;

    legal = '{OpR, OpLw, OpSw, OpBeq, OpJ, OpAddi};
    outTab = '{OFetch, ODecode, OMemAdr, OMemRd, OMemWb, OMemWr, OExec, ORwb,
               OBranch, OJump, OAddiEx, OAddiWb};

    // Reset held with memReady high: FETCH decode but no fetch strobes.
    addVec(0, OpR, 1, 0, OFetch);
    // R-type
    addVec(1, OpR, 1, 0, OFetchR); addVec(1, OpR, 1, 1, ODecode);
    addVec(1, OpR, 1, 6, OExec);   addVec(1, OpR, 1, 7, ORwb);
    // lw with two MEMRD wait cycles
    addVec(1, OpLw, 1, 0, OFetchR); addVec(1, OpLw, 1, 1, ODecode);
    addVec(1, OpLw, 1, 2, OMemAdr); addVec(1, OpLw, 0, 3, OMemRd);
    addVec(1, OpLw, 0, 3, OMemRd);  addVec(1, OpLw, 1, 3, OMemRd);
    addVec(1, OpLw, 1, 4, OMemWb);
    // sw
    addVec(1, OpSw, 1, 0, OFetchR); addVec(1, OpSw, 1, 1, ODecode);
    addVec(1, OpSw, 1, 2, OMemAdr); addVec(1, OpSw, 1, 5, OMemWr);
    // beq, j, illegal
    addVec(1, OpBeq, 1, 0, OFetchR); addVec(1, OpBeq, 1, 1, ODecode);
    addVec(1, OpBeq, 1, 8, OBranch);
    addVec(1, OpJ, 1, 0, OFetchR);   addVec(1, OpJ, 1, 1, ODecode);
    addVec(1, OpJ, 1, 9, OJump);
    addVec(1, OpBad, 1, 0, OFetchR); addVec(1, OpBad, 1, 1, ODecode);
    // FETCH stall
    addVec(1, OpR, 0, 0, OFetch);    addVec(1, OpR, 0, 0, OFetch);
    // Reset during a MEMWR wait
    addVec(1, OpSw, 1, 0, OFetchR);  addVec(1, OpSw, 1, 1, ODecode);
    addVec(1, OpSw, 1, 2, OMemAdr);  addVec(1, OpSw, 0, 5, OMemWr);
    addVec(0, OpSw, 0, 5, OFetch);   addVec(0, OpSw, 1, 0, OFetch);
    // Reset during a MEMRD wait
    addVec(1, OpLw, 1, 0, OFetchR);  addVec(1, OpLw, 1, 1, ODecode);
    addVec(1, OpLw, 1, 2, OMemAdr);  addVec(1, OpLw, 0, 3, OMemRd);
    addVec(0, OpLw, 0, 3, OFetch);
    // addi, ending at an instruction boundary
    addVec(1, OpAddi, 1, 0, OFetchR); addVec(1, OpAddi, 1, 1, ODecode);
    addVec(1, OpAddi, 1, 10, OAddiEx); addVec(1, OpAddi, 1, 11, OAddiWb);

    rst_n    = 1'b0;
    opcode   = 6'h00;
    memReady = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      step(vecs[i].rstN, vecs[i].op, vecs[i].mr, vecs[i].st, vecs[i].out,
           $sformatf("vec %0d", i));
    end

    // Random instruction stream with random memory wait states.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 6) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (isLegal(op));
      end else begin
        op = legal[$urandom_range(0, 5)];
      end
      buildPath(op);
      pcWrites = 0;
      foreach (path[i]) begin
        st = path[i];
        if (st == 0 || st == 3 || st == 5) begin
          waits = $urandom_range(0, 2);
          repeat (waits) step(1'b1, op, 1'b0, 4'(st), outTab[st],
                              $sformatf("rand %0d op %b wait", n, op));
          step(1'b1, op, 1'b1, 4'(st), outTab[st] | ((st == 0) ? RdyBits : 16'h0),
               $sformatf("rand %0d op %b", n, op));
        end else begin
          step(1'b1, op, 1'($urandom_range(0, 1)), 4'(st), outTab[st],
               $sformatf("rand %0d op %b", n, op));
        end
      end
      check($sformatf("rand %0d pcWrite count", n), 16'(pcWrites), 16'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have ports: rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
REQ-003 SHALL have ports: opcode  input  6  instr[31:26] from instruction register.
REQ-004 SHALL have ports: memReady  input  1  memory access complete this cycle.
REQ-005 SHALL have ports: pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst, regWrite, aluSrcA  output  1 each  datapath strobes/selects.
REQ-006 SHALL have ports: aluSrcB, aluOp, pcSource  output  2 each  4:1 mux selects and ALU op class.
REQ-007 SHALL have ports: state  output  4  current FSM state, debug only.
REQ-008 SHALL have no parameters; one clock; reset synchronous, active-low.

Function
REQ-009 SHALL implement a Moore FSM; the only Mealy term is memReady qualifying REQ-011/REQ-016/REQ-017.
REQ-010 SHALL use states (code): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
REQ-011 FETCH SHALL drive memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00; irWrite=pcWrite=memReady; stay while memReady=0, else go DECODE.
REQ-012 DECODE SHALL drive aluSrcA=0, aluSrcB=11, aluOp=00; next by opcode: 000000 EXEC, 100011/101011 MEMADR, 000100 BRANCH, 000010 JUMP, 001000 ADDIEX, any other FETCH.
REQ-013 MEMADR SHALL drive aluSrcA=1, aluSrcB=10, aluOp=00; next MEMRD if opcode=100011, else MEMWR.
REQ-014 EXEC SHALL drive aluSrcA=1, aluSrcB=00, aluOp=10; next RWB.
REQ-015 RWB SHALL drive regDst=1, regWrite=1, memToReg=0; next FETCH.
REQ-016 MEMRD SHALL drive memRead=1, iorD=1; stay while memReady=0, else MEMWB.
REQ-017 MEMWR SHALL drive memWrite=1, iorD=1; stay while memReady=0, else FETCH; memWrite SHALL remain asserted every cycle of the wait.
REQ-018 MEMWB SHALL drive regDst=0, regWrite=1, memToReg=1; next FETCH.
REQ-019 BRANCH SHALL drive aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01; next FETCH.
REQ-020 JUMP SHALL drive pcWrite=1, pcSource=10; next FETCH.
REQ-021 ADDIEX SHALL drive aluSrcA=1, aluSrcB=10, aluOp=00; next ADDIWB; ADDIWB SHALL drive regDst=0, regWrite=1, memToReg=0; next FETCH.
REQ-022 Every output not listed for a state SHALL be 0 (2-bit fields 00); no output SHALL be X in any state.
REQ-023 Unused state codes 12-15 SHALL drive all outputs 0 and transition to FETCH next cycle.
REQ-024 Latency (memReady=1 throughout): R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2; each wait cycle adds 1.
REQ-025 memWrite and regWrite SHALL never be asserted in the same cycle; pcWrite SHALL assert at most once per instruction outside JUMP.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force state=FETCH regardless of current state, including mid-wait in MEMRD/MEMWR.
REQ-027 While in reset, outputs SHALL follow FETCH decode with irWrite=pcWrite=0 (forced by reset, not memReady).
REQ-028 First cycle after rst_n released SHALL be FETCH with full REQ-011 behaviour.

Verification
REQ-029 Reset, then opcode=000000, memReady=1 -> states 0,1,6,7,0; regWrite=1,regDst=1 only in state 7.
REQ-030 opcode=100011, memReady low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; memRead=1,iorD=1 all three MEMRD cycles.
REQ-031 opcode=101011, memReady=1 -> states 0,1,2,5,0; memWrite=1 one cycle, regWrite never 1.
REQ-032 opcode=000100 then 000010 -> BRANCH pcWriteCond=1,pcSource=01; JUMP pcWrite=1,pcSource=10; each 3 cycles.
REQ-033 opcode=111111 -> states 0,1,0; no write strobe asserted.
REQ-034 rst_n=0 during MEMWR wait (memReady=0) -> next state 0, memWrite=0 next cycle, irWrite=pcWrite=0 while rst_n=0.
